rom_port_arbiter: RTL

ROM_PORT_ARBITER -- requirements
Module: rom_port_arbiter

---
 rtl/rom_port_arbiter_pkg.sv | 50 +++++
 rtl/rom_tag_pipe.sv | 45 ++++
 rtl/rom_port_arbiter.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/rom_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// rom_port_arbiter_pkg
// Shared definitions for the image-ROM port arbiter:
//   - default geometry of the image ROM (address width, R/G/B pixel widths)
//   - default ROM read latency and aux starvation threshold
//   - slot owner enum and the tag that travels alongside each ROM read
//   - small helpers used by the arbiter and its tag delay line
// -----------------------------------------------------------------------------
package rom_port_arbiter_pkg;

  // Image ROM geometry.
  localparam int ROM_ADDR_BUS_WIDTH = 17;
  localparam int R_WIDTH            = 8;
  localparam int G_WIDTH            = 8;
  localparam int B_WIDTH            = 8;
  localparam int PIX_WIDTH          = R_WIDTH + G_WIDTH + B_WIDTH;

  // Cycles from a rom_addr change to valid rom_data (legal range 1..4).
  localparam int ROM_LATENCY        = 2;

  // Aux wait cycles before aux_starved is raised.
  localparam int STARVE_LIMIT       = 1023;

  // Who a ROM read slot belongs to.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_DISP = 2'd1,
    OWN_AUX  = 2'd2
  } owner_e;

  // Tag carried through the latency pipeline next to each ROM read.
  typedef struct packed {
    logic   valid;
    owner_e owner;
  } slot_tag_t;

  localparam slot_tag_t TAG_EMPTY = '{valid: 1'b0, owner: OWN_NONE};

  // True when a tag marks a live slot owned by the given requester.
  function automatic logic tag_is(input slot_tag_t tag, input owner_e owner);
    return tag.valid && (tag.owner == owner);
  endfunction

  // Width of a counter that can reach 'limit'; it saturates at all-ones,
  // so a limit of 2^k-1 yields exactly k bits (1023 -> 10 bits).
  function automatic int wait_cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage : rom_port_arbiter_pkg

// File: rtl/rom_tag_pipe.sv
// -----------------------------------------------------------------------------
// rom_tag_pipe
// Fixed-depth delay line for slot tags. A tag entered with a ROM address
// emerges DEPTH cycles later, aligned with the ROM data of that address.
// Reset empties every stage so reads in flight at reset produce no response.
//
// Ports
//   clk    in   1           rising-edge clock
//   reset  in   1           asynchronous active-high reset
//   i_tag  in   slot_tag_t  tag of the slot being issued this cycle
//   o_tag  out  slot_tag_t  tag of the slot whose data is on the ROM now
// -----------------------------------------------------------------------------
module rom_tag_pipe
  import rom_port_arbiter_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic      clk,
  input  logic      reset,
  input  slot_tag_t i_tag,
  output slot_tag_t o_tag
);

  slot_tag_t r_stage [DEPTH];

  // NOTE: every stage is reset here because a stale tag would fabricate a
  //       valid response; a plain data delay line would not need it. State
  //       is updated with non-blocking assignments so all stages shift on
  //       the same edge instead of ripple-copying in one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i] <= TAG_EMPTY;
      end
    end else begin
      r_stage[0] <= i_tag;
      for (int i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_tag = r_stage[DEPTH-1];

endmodule : rom_tag_pipe

// File: rtl/rom_port_arbiter.sv
// -----------------------------------------------------------------------------
// rom_port_arbiter
// Shares one single-port image ROM between the display path (absolute
// priority, fixed latency) and a secondary aux requester (served in idle
// display cycles, in order, one response per grant).
//
// Each cycle the winner's address is registered onto rom_addr and a tag
// {valid, owner} is pushed into a ROM_LATENCY+1 deep tag pipe so that the
// tag leaves the pipe in the same cycle the ROM returns that address's data.
// The tag then steers rom_data to the display or aux output.
//
// Ports
//   clk          in   1                   system/pixel clock
//   reset        in   1                   asynchronous active-high reset
//   disp_req     in   1                   display wants a pixel this cycle
//   disp_addr    in   ROM_ADDR_BUS_WIDTH  display ROM address
//   disp_data    out  PIX_WIDTH           pixel, black when not a display slot
//   disp_valid   out  1                   disp_data carries ROM data
//   aux_req      in   1                   aux read request (level)
//   aux_addr     in   ROM_ADDR_BUS_WIDTH  aux address, stable while aux_req
//   aux_gnt      out  1                   aux request accepted this cycle
//   aux_data     out  PIX_WIDTH           aux read data, holds between reads
//   aux_valid    out  1                   qualifies aux_data for one cycle
//   aux_starved  out  1                   aux waited >= STARVE_LIMIT cycles
//   rom_addr     out  ROM_ADDR_BUS_WIDTH  registered ROM address
//   rom_data     in   PIX_WIDTH           ROM read data
// -----------------------------------------------------------------------------
module rom_port_arbiter #(
  parameter int ROM_ADDR_BUS_WIDTH = rom_port_arbiter_pkg::ROM_ADDR_BUS_WIDTH,
  parameter int PIX_WIDTH          = rom_port_arbiter_pkg::PIX_WIDTH,
  parameter int ROM_LATENCY        = rom_port_arbiter_pkg::ROM_LATENCY,
  parameter int STARVE_LIMIT       = rom_port_arbiter_pkg::STARVE_LIMIT
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          disp_req,
  input  logic [ROM_ADDR_BUS_WIDTH-1:0] disp_addr,
  output logic [PIX_WIDTH-1:0]          disp_data,
  output logic                          disp_valid,
  input  logic                          aux_req,
  input  logic [ROM_ADDR_BUS_WIDTH-1:0] aux_addr,
  output logic                          aux_gnt,
  output logic [PIX_WIDTH-1:0]          aux_data,
  output logic                          aux_valid,
  output logic                          aux_starved,
  output logic [ROM_ADDR_BUS_WIDTH-1:0] rom_addr,
  input  logic [PIX_WIDTH-1:0]          rom_data
);

  import rom_port_arbiter_pkg::*;

  // One stage for the address register plus ROM_LATENCY stages for the ROM.
  localparam int TAG_DEPTH = ROM_LATENCY + 1;

  localparam int                WAIT_W        = wait_cnt_width(STARVE_LIMIT);
  localparam logic [WAIT_W-1:0] STARVE_THRESH = WAIT_W'(STARVE_LIMIT);

  // ---------------------------------------------------------------------------
  // Arbitration: display always wins; aux only takes display-idle cycles.
  // ---------------------------------------------------------------------------
  logic      w_aux_win;
  slot_tag_t w_issue_tag;

  assign w_aux_win = aux_req & ~disp_req;

  // Grant is combinational from this cycle's requests; masked during reset
  // so nothing is accepted while the pipe is being flushed.
  assign aux_gnt = w_aux_win & ~reset;

  // NOTE: the default assignment first keeps this block purely
  //       combinational; without it the no-request path would infer a latch.
  always_comb begin
    w_issue_tag = TAG_EMPTY;
    if (disp_req) begin
      w_issue_tag = '{valid: 1'b1, owner: OWN_DISP};
    end else if (aux_req) begin
      w_issue_tag = '{valid: 1'b1, owner: OWN_AUX};
    end
  end

  // ---------------------------------------------------------------------------
  // ROM address register: follows the winner, holds when nobody asks.
  // ---------------------------------------------------------------------------
  logic [ROM_ADDR_BUS_WIDTH-1:0] r_rom_addr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rom_addr <= '0;
    end else if (disp_req) begin
      r_rom_addr <= disp_addr;
    end else if (aux_req) begin
      r_rom_addr <= aux_addr;
    end
  end

  assign rom_addr = r_rom_addr;

  // ---------------------------------------------------------------------------
  // Tag delay line aligned with rom_data.
  // ---------------------------------------------------------------------------
  slot_tag_t w_ret_tag;

  rom_tag_pipe #(
    .DEPTH (TAG_DEPTH)
  ) u_tag_pipe (
    .clk   (clk),
    .reset (reset),
    .i_tag (w_issue_tag),
    .o_tag (w_ret_tag)
  );

  // ---------------------------------------------------------------------------
  // Response steering.
  // ---------------------------------------------------------------------------
  logic                 w_disp_slot;
  logic                 w_aux_slot;
  logic [PIX_WIDTH-1:0] r_aux_hold;

  assign w_disp_slot = tag_is(w_ret_tag, OWN_DISP);
  assign w_aux_slot  = tag_is(w_ret_tag, OWN_AUX);

  // Display gets black fill in any slot that is not its own.
  assign disp_valid = w_disp_slot;
  assign disp_data  = w_disp_slot ? rom_data : '0;

  // Aux data is live in its slot and otherwise replays the last aux word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_aux_hold <= '0;
    end else if (w_aux_slot) begin
      r_aux_hold <= rom_data;
    end
  end

  assign aux_valid = w_aux_slot;
  assign aux_data  = w_aux_slot ? rom_data : r_aux_hold;

  // ---------------------------------------------------------------------------
  // Aux starvation monitor: counts consecutive denied cycles; advisory only.
  // ---------------------------------------------------------------------------
  logic [WAIT_W-1:0] r_wait_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wait_cnt <= '0;
    end else if (!aux_req || w_aux_win) begin
      r_wait_cnt <= '0;
    end else if (r_wait_cnt != '1) begin
      r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
    end
  end

  assign aux_starved = (r_wait_cnt >= STARVE_THRESH);

endmodule : rom_port_arbiter
